// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: unit latencies, hazard result struct, scoreboard defaults.
package pipeline_pkg;

  localparam int unsigned CNT_W_DEFAULT = 3;

  // Cycles from issue until the result can be forwarded.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_DIV  = 7;

  typedef struct packed {
    logic       stall;
    logic [1:0] stall_src;
  } hazard_t;

endpackage

// File: rtl/scoreboard_cell.sv
// One register's pending-latency counter: set on issue, count down to zero, freeze on hold.
module scoreboard_cell #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             set_i,
  input  logic [CNT_W-1:0] set_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] count_d, count_q;

  // Hold beats set, and set beats the decrement of an older producer.
  always_comb begin
    count_d = count_q;
    if (hold_i) begin
      count_d = count_q;
    end else if (set_i) begin
      count_d = set_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign pending_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard unit: per-register latency scoreboard driving the ID stall.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned REG_W  = $clog2(NREG),
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic              issue,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              issue_rd_en,
  input  logic [CNT_W-1:0]  issue_lat,
  input  logic              hold,
  output logic              stall,
  output logic [1:0]        stall_src,
  output logic [NREG-1:0]   pending_mask,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [CNT_W-1:0]  count [NREG];
  hazard_t           haz;
  logic              rs1_haz, rs2_haz;
  logic [PERF_W-1:0] perf_d, perf_q;

  // x0 never holds pending state.
  assign count[0]        = '0;
  assign pending_mask[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cell
    scoreboard_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk_i     (clk),
      .rst_i     (rst),
      .hold_i    (hold),
      .set_i     (issue & issue_rd_en & (issue_rd == REG_W'(r))),
      .set_val_i (issue_lat),
      .count_o   (count[r]),
      .pending_o (pending_mask[r])
    );
  end

  always_comb begin
    rs1_haz = id_valid & id_rs1_en & (id_rs1 != '0) & (count[id_rs1] != '0);
    rs2_haz = id_valid & id_rs2_en & (id_rs2 != '0) & (count[id_rs2] != '0);
    haz           = '0;
    haz.stall     = rs1_haz | rs2_haz;
    haz.stall_src = {rs2_haz, rs1_haz};
  end

  assign stall     = haz.stall;
  assign stall_src = haz.stall_src;

  always_comb begin
    perf_d = perf_q;
    if (haz.stall && !hold) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a per-register countdown model.
module tb_hazard_scoreboard;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_en, id_rs2_en;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        issue_rd_en;
  logic [2:0]  issue_lat;
  logic        hold;
  logic        stall;
  logic [1:0]  stall_src;
  logic [31:0] pending_mask;
  logic [31:0] stall_cycles;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          armed    = 1'b0;

  // Reference model: remaining cycles per register and the stall counter.
  int          cnt [NREG];
  logic [31:0] perf;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_en    (id_rs1_en),
    .id_rs2_en    (id_rs2_en),
    .issue        (issue),
    .issue_rd     (issue_rd),
    .issue_rd_en  (issue_rd_en),
    .issue_lat    (issue_lat),
    .hold         (hold),
    .stall        (stall),
    .stall_src    (stall_src),
    .pending_mask (pending_mask),
    .stall_cycles (stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_src();
    logic h1, h2;
    h1 = id_valid && id_rs1_en && id_rs1 != 0 && cnt[id_rs1] > 0;
    h2 = id_valid && id_rs2_en && id_rs2 != 0 && cnt[id_rs2] > 0;
    return {h2, h1};
  endfunction

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
    issue = 0; issue_rd = 0; issue_rd_en = 0; issue_lat = 0; hold = 0;
  endtask

  // Inputs are driven at the negedge; this checks, crosses one posedge, returns at the next negedge.
  task automatic cycle();
    logic [1:0]  src;
    logic [31:0] mask;
    #1;
    src  = model_src();
    mask = '0;
    for (int r = 0; r < NREG; r++) mask[r] = (cnt[r] > 0);
    if (armed) begin
      check_eq("stall", 64'(stall), 64'(|src));
      check_eq("stall_src", 64'(stall_src), 64'(src));
      check_eq("pending_mask", 64'(pending_mask), 64'(mask));
      check_eq("stall_cycles", 64'(stall_cycles), 64'(perf));
      if (issue && !rst) check_eq("issue_while_stall", 64'(stall), 64'(0));
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] = 0;
      perf = '0;
    end else if (!hold) begin
      if (|src) perf = perf + 1;
      for (int r = 1; r < NREG; r++) begin
        if (issue && issue_rd_en && issue_rd == 5'(r)) cnt[r] = int'(issue_lat);
        else if (cnt[r] > 0) cnt[r] = cnt[r] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic do_issue(input int rd, input int lat);
    clear_inputs();
    issue = 1; issue_rd_en = 1; issue_rd = 5'(rd); issue_lat = 3'(lat);
    cycle();
    clear_inputs();
  endtask

  initial begin
    logic [1:0] both_exp [3];
    clear_inputs();
    rst = 1;
    cycle();
    armed = 1'b1;
    rst = 0;

    // Load-use: exactly one bubble.
    do_issue(5, 1);
    id_valid = 1; id_rs1 = 5; id_rs1_en = 1;
    #1 check_eq("lu_stall", 64'(stall), 64'(1));
    check_eq("lu_src", 64'(stall_src), 64'(2'b01));
    cycle();
    #1 check_eq("lu_release", 64'(stall), 64'(0));
    check_eq("lu_perf", 64'(stall_cycles), 64'(1));
    cycle();

    // Multi-cycle producer, two held cycles stretch the stall to six.
    do_reset();
    do_issue(7, 4);
    id_valid = 1; id_rs2 = 7; id_rs2_en = 1;
    for (int i = 0; i < 6; i++) begin
      hold = (i == 1 || i == 2);
      #1 check_eq("mc_stall", 64'(stall), 64'(1));
      check_eq("mc_src", 64'(stall_src), 64'(2'b10));
      cycle();
    end
    hold = 0;
    #1 check_eq("mc_release", 64'(stall), 64'(0));
    check_eq("mc_perf", 64'(stall_cycles), 64'(4));
    cycle();

    // x0 and zero-latency writes never stall.
    do_reset();
    do_issue(0, 7);
    do_issue(3, 0);
    id_valid = 1; id_rs1 = 0; id_rs2 = 3; id_rs1_en = 1; id_rs2_en = 1;
    #1 check_eq("zero_stall", 64'(stall), 64'(0));
    check_eq("zero_mask", 64'(pending_mask), 64'(0));
    cycle();

    // Later issue replaces a longer remaining count.
    do_reset();
    do_issue(9, 5);
    cycle();
    do_issue(9, 1);
    #1 check_eq("ovr_pending", 64'(pending_mask[9]), 64'(1));
    cycle();
    #1 check_eq("ovr_clear", 64'(pending_mask[9]), 64'(0));
    cycle();

    // Both sources pending with different latencies.
    do_reset();
    do_issue(4, 3);
    do_issue(6, 1);
    both_exp[0] = 2'b11; both_exp[1] = 2'b01; both_exp[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_rs1 = 4; id_rs2 = 6; id_rs1_en = 1; id_rs2_en = 1;
      #1 check_eq("both_src", 64'(stall_src), 64'(both_exp[i]));
      cycle();
    end

    // Reset mid-operation discards pending state and the counter.
    do_reset();
    do_issue(12, 6);
    id_valid = 1; id_rs1 = 12; id_rs1_en = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1 check_eq("rst_mask", 64'(pending_mask), 64'(0));
    check_eq("rst_stall", 64'(stall), 64'(0));
    check_eq("rst_perf", 64'(stall_cycles), 64'(0));
    cycle();

    // Randomized traffic on a narrow register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      hold        = ($urandom_range(0, 7) == 0);
      id_valid    = 1'($urandom);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_en   = 1'($urandom);
      id_rs2_en   = 1'($urandom);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rd_en = ($urandom_range(0, 3) != 0);
      issue_lat   = 3'($urandom);
      issue       = 1'($urandom) && (model_src() == 2'b00);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
